// File: rtl/regex_imem_arbiter.sv
// ---------------------------------------------------------------------------
// regex_imem_arbiter
//
// Lets N_CPU regex CPU cores share one single-port instruction BRAM with a
// one-cycle read latency. The program loader has priority write access.
// Cores are served round-robin, one access per cycle. A saturating counter
// records every cycle in which two or more requesters compete.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cpu_valid       per-core fetch request, held until cpu_ready
//   cpu_addr        per-core address, core i uses [i*AW +: AW]
//   cpu_ready       one-hot grant or all zero (combinational)
//   cpu_data        broadcast read data (equal to mem_rdata)
//   load_valid/addr/data, load_ready   loader write port
//   mem_en/we/addr/wdata, mem_rdata    BRAM port
//   resp_valid      cpu_data holds the response to last cycle's read grant
//   resp_id         core that owns the current response
//   contention_cnt  saturating count of cycles with >= 2 active requesters
// ---------------------------------------------------------------------------
module regex_imem_arbiter #(
    parameter int N_CPU             = 4,
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CPU-1:0]                   cpu_valid,
    input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_addr,
    output logic [N_CPU-1:0]                   cpu_ready,
    output logic [MEMORY_WIDTH-1:0]            cpu_data,
    input  logic                               load_valid,
    input  logic [MEMORY_ADDR_WIDTH-1:0]       load_addr,
    input  logic [MEMORY_WIDTH-1:0]            load_data,
    output logic                               load_ready,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
    output logic [MEMORY_WIDTH-1:0]            mem_wdata,
    input  logic [MEMORY_WIDTH-1:0]            mem_rdata,
    output logic                               resp_valid,
    output logic [$clog2(N_CPU)-1:0]           resp_id,
    output logic [CNT_WIDTH-1:0]               contention_cnt
);

    localparam int ID_W = $clog2(N_CPU);
    localparam int AW   = MEMORY_ADDR_WIDTH;

    // Registered state
    logic [ID_W-1:0]      rr_ptr_q,     rr_ptr_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]      resp_id_q,    resp_id_d;
    logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;

    // Combinational grant path
    logic                    gnt_found_s;
    logic [ID_W-1:0]         gnt_idx_s;
    logic [N_CPU-1:0]        cpu_ready_s;
    logic                    load_ready_s;
    logic                    mem_en_s;
    logic                    mem_we_s;
    logic [AW-1:0]           mem_addr_s;
    logic [MEMORY_WIDTH-1:0] mem_wdata_s;
    logic                    multi_req_s;

    // Number of set bits in a request vector.
    function automatic int unsigned count_ones(input logic [N_CPU-1:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < N_CPU; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Round-robin search: first requesting core at or after rr_ptr, wrapping.
    always_comb begin
        int idx_v;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        idx_v       = 0;
        for (int k = 0; k < N_CPU; k++) begin
            idx_v = (int'(rr_ptr_q) + k) % N_CPU;
            if (!gnt_found_s && cpu_valid[idx_v[ID_W-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = idx_v[ID_W-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Contention detect: cores plus loader counted as requesters.
    always_comb begin
        multi_req_s = (count_ones(cpu_valid) + 32'(load_valid)) >= 32'd2;
    end

    // Access selection and next-state: loader beats cores; reset suppresses
    // every grant so nothing issued in a reset cycle reaches the BRAM.
    always_comb begin
        cpu_ready_s  = '0;
        load_ready_s = 1'b0;
        mem_en_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        if (rst) begin
            cpu_ready_s  = '0;
            load_ready_s = 1'b0;
        end else if (load_valid) begin
            load_ready_s = 1'b1;
            mem_en_s     = 1'b1;
            mem_we_s     = 1'b1;
            mem_addr_s   = load_addr;
            mem_wdata_s  = load_data;
        end else if (gnt_found_s) begin
            cpu_ready_s[gnt_idx_s] = 1'b1;
            mem_en_s               = 1'b1;
            mem_addr_s             = cpu_addr[int'(gnt_idx_s)*AW +: AW];
            resp_valid_d           = 1'b1;
            resp_id_d              = gnt_idx_s;
            // Explicit wrap keeps the pointer legal when N_CPU is not a power of two.
            if (gnt_idx_s == ID_W'(N_CPU - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx_s + ID_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Saturating contention counter next value.
    always_comb begin
        if (multi_req_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            cnt_q        <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cpu_ready      = cpu_ready_s;
    assign load_ready     = load_ready_s;
    assign mem_en         = mem_en_s;
    assign mem_we         = mem_we_s;
    assign mem_addr       = mem_addr_s;
    assign mem_wdata      = mem_wdata_s;
    assign cpu_data       = mem_rdata;
    // A response still in flight when reset arrives is dropped immediately.
    assign resp_valid     = resp_valid_q & ~rst;
    assign resp_id        = resp_id_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_regex_imem_arbiter.sv
// Directed bench for regex_imem_arbiter: table of single-cycle vectors plus
// hand-written sequences for round-robin order, saturation and reset.
module tb_regex_imem_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  cv;
    logic [43:0] ca;
    logic        lv;
    logic [10:0] la;
    logic [19:0] ld;
    logic [19:0] mem_rdata;

    logic [3:0]  cpu_ready;
    logic [19:0] cpu_data;
    logic        load_ready, mem_en, mem_we, resp_valid;
    logic [10:0] mem_addr;
    logic [19:0] mem_wdata;
    logic [1:0]  resp_id;
    logic [31:0] cnt;

    logic [3:0]  s_ready;
    logic [19:0] s_data, s_wdata;
    logic        s_lrdy, s_en, s_we, s_rv;
    logic [10:0] s_addr;
    logic [1:0]  s_id;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] mem [0:2047];

    regex_imem_arbiter u_dut (
        .clk(clk), .rst(rst), .cpu_valid(cv), .cpu_addr(ca), .cpu_ready(cpu_ready),
        .cpu_data(cpu_data), .load_valid(lv), .load_addr(la), .load_data(ld),
        .load_ready(load_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_id(resp_id), .contention_cnt(cnt)
    );

    regex_imem_arbiter #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .cpu_valid(cv), .cpu_addr(ca), .cpu_ready(s_ready),
        .cpu_data(s_data), .load_valid(lv), .load_addr(la), .load_data(ld),
        .load_ready(s_lrdy), .mem_en(s_en), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .mem_rdata(mem_rdata), .resp_valid(s_rv),
        .resp_id(s_id), .contention_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: one-cycle read latency, write on mem_we.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [3:0]  cv;
        logic [43:0] ca;
        logic        lv;
        logic [10:0] la;
        logic [19:0] ld;
        logic [3:0]  e_rdy;
        logic        e_lrdy;
        logic        e_en;
        logic        e_we;
        logic [10:0] e_addr;
        logic        e_rv;
        logic [1:0]  e_id;
        logic [19:0] e_data;
        logic [31:0] e_cnt;
    } vec_t;

    localparam logic [43:0] A0 = {11'h023, 11'h005, 11'h021, 11'h020};
    localparam logic [43:0] A1 = {11'h023, 11'h005, 11'h021, 11'h010};

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 20'h30000 + 20'(i);
        mem[5] = 20'h1ABCD;
        mem_rdata = 20'h0;

        //           cv       ca  lv  la      ld         rdy      lrdy  en    we    addr     rv    id    data        cnt
        vecs[0] = '{4'b0100, A0, 1'b0, 11'h0,  20'h0,     4'b0100, 1'b0, 1'b1, 1'b0, 11'h005, 1'b0, 2'd0, 20'h0,     32'd0};
        vecs[1] = '{4'b0000, A0, 1'b0, 11'h0,  20'h0,     4'b0000, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 2'd2, 20'h1ABCD, 32'd0};
        vecs[2] = '{4'b0001, A0, 1'b0, 11'h0,  20'h0,     4'b0001, 1'b0, 1'b1, 1'b0, 11'h020, 1'b0, 2'd2, 20'h0,     32'd0};
        vecs[3] = '{4'b0101, A0, 1'b0, 11'h0,  20'h0,     4'b0100, 1'b0, 1'b1, 1'b0, 11'h005, 1'b1, 2'd0, 20'h30020, 32'd0};
        vecs[4] = '{4'b1000, A0, 1'b0, 11'h0,  20'h0,     4'b1000, 1'b0, 1'b1, 1'b0, 11'h023, 1'b1, 2'd2, 20'h1ABCD, 32'd1};
        vecs[5] = '{4'b0011, A1, 1'b1, 11'h010, 20'h00123, 4'b0000, 1'b1, 1'b1, 1'b1, 11'h010, 1'b1, 2'd3, 20'h30023, 32'd1};
        vecs[6] = '{4'b0011, A1, 1'b0, 11'h0,  20'h0,     4'b0001, 1'b0, 1'b1, 1'b0, 11'h010, 1'b0, 2'd3, 20'h0,     32'd2};
        vecs[7] = '{4'b0010, A1, 1'b0, 11'h0,  20'h0,     4'b0010, 1'b0, 1'b1, 1'b0, 11'h021, 1'b1, 2'd0, 20'h00123, 32'd3};
        vecs[8] = '{4'b0000, A1, 1'b0, 11'h0,  20'h0,     4'b0000, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 2'd1, 20'h30021, 32'd3};

        // Reset with requests present: nothing may be granted.
        rst = 1'b1; cv = 4'b1111; ca = A0; lv = 1'b1; la = 11'h7FF; ld = 20'hFFFFF;
        tick();
        #4;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0; cv = 4'b0000; lv = 1'b0; la = 11'h0; ld = 20'h0;
        #4;
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_resp_id", 32'(resp_id), 32'd0);
        chk("post_rst_cnt", cnt, 32'd0);
        chk("post_rst_sat_cnt", 32'(s_cnt), 32'd0);
        chk("post_rst_mem_en", 32'(mem_en), 32'd0);
        tick();

        // Table of single-cycle vectors.
        for (int i = 0; i < 9; i++) begin
            cv = vecs[i].cv; ca = vecs[i].ca; lv = vecs[i].lv; la = vecs[i].la; ld = vecs[i].ld;
            #4;
            chk($sformatf("v%0d_cpu_ready", i), 32'(cpu_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_load_ready", i), 32'(load_ready), 32'(vecs[i].e_lrdy));
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            if (vecs[i].e_en) chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            if (vecs[i].e_we) chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].ld));
            chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_resp_id", i), 32'(resp_id), 32'(vecs[i].e_id));
            if (vecs[i].e_rv) chk($sformatf("v%0d_cpu_data", i), 32'(cpu_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d_cnt", i), cnt, vecs[i].e_cnt);
            tick();
        end

        // All cores hold valid for 20 cycles: strict rotation, counter saturates at 15 on the narrow copy.
        rst = 1'b1; cv = 4'b0000; lv = 1'b0; ca = A0;
        tick();
        tick();
        rst = 1'b0; cv = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            #4;
            chk($sformatf("rr%0d_cpu_ready", k), 32'(cpu_ready), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr%0d_cnt", k), cnt, 32'(k));
            chk($sformatf("rr%0d_sat_cnt", k), 32'(s_cnt), 32'((k < 15) ? k : 15));
            chk($sformatf("rr%0d_resp_valid", k), 32'(resp_valid), 32'((k > 0) ? 1 : 0));
            if (k > 0) chk($sformatf("rr%0d_resp_id", k), 32'(resp_id), 32'((k - 1) % 4));
            tick();
        end
        #4;
        chk("sat_final_cnt", cnt, 32'd20);
        chk("sat_final_sat_cnt", 32'(s_cnt), 32'd15);

        // Reset in the cycle after core 1's grant drops the response and rewinds rr_ptr.
        tick();
        cv = 4'b0010;
        #4;
        chk("mid_rst_grant1", 32'(cpu_ready), 32'b0010);
        tick();
        rst = 1'b1;
        #4;
        chk("mid_rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0; cv = 4'b0000;
        #4;
        chk("after_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("after_rst_resp_id", 32'(resp_id), 32'd0);
        chk("after_rst_cnt", cnt, 32'd0);
        tick();
        cv = 4'b1111;
        #4;
        chk("after_rst_rr_ptr0", 32'(cpu_ready), 32'b0001);
        tick();
        cv = 4'b0000;
        #4;
        chk("after_rst_resp_valid2", 32'(resp_valid), 32'd1);
        chk("after_rst_cpu_data", 32'(cpu_data), 32'h30020);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
